// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 state encoding, command/response bytes and parity helper
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQUEST,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_ACK,
        ST_WAIT_IDLE
    } tx_state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-FF synchronizer for PS/2 clock/data plus clock falling-edge strobe
module ps2_line_sync (
    input  logic clock,
    input  logic reset,
    input  logic ps2_clk_in,
    input  logic ps2_dat_in,
    output logic clk_sync,
    output logic dat_sync,
    output logic fall_edge
);

    logic [1:0] clk_ff;
    logic [1:0] dat_ff;
    logic       clk_prev;

    // Idle lines float high, so reset to 1 to avoid a spurious edge after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_ff   <= 2'b11;
            dat_ff   <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], ps2_clk_in};
            dat_ff   <= {dat_ff[0], ps2_dat_in};
            clk_prev <= clk_ff[1];
        end
    end

    assign clk_sync  = clk_ff[1];
    assign dat_sync  = dat_ff[1];
    assign fall_edge = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter over open-drain enables
// Define PS2_HOST_TX_ACK_CHECK_EN to turn a missing device ACK into an error pulse.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       send,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);
    import ps2_pkg::*;

    localparam int MAX_COUNT = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CW        = $clog2(MAX_COUNT + 1);
    // The request cycle also holds the clock low, so INHIBIT itself lasts one cycle less.
    localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 2);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    tx_state_t     state;
    logic [7:0]    tx_byte;
    logic          tx_parity;
    logic [2:0]    bit_cnt;
    logic [CW-1:0] cycle_cnt;

    logic clk_sync;
    logic dat_sync;
    logic fall_edge;
    logic line_phase;
    logic lines_idle;
    logic timed_out;

    ps2_line_sync u_line_sync (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .clk_sync   (clk_sync),
        .dat_sync   (dat_sync),
        .fall_edge  (fall_edge)
    );

    assign line_phase = (state == ST_DATA) || (state == ST_PARITY) || (state == ST_STOP) ||
                        (state == ST_ACK) || (state == ST_WAIT_IDLE);
    assign lines_idle = clk_sync & dat_sync;
    assign timed_out  = line_phase && !fall_edge && (cycle_cnt == TIMEOUT_LAST) &&
                        !((state == ST_WAIT_IDLE) && lines_idle);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            tx_byte    <= '0;
            tx_parity  <= 1'b0;
            bit_cnt    <= '0;
            cycle_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (timed_out) begin
                error      <= 1'b1;
                busy       <= 1'b0;
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
                cycle_cnt  <= '0;
                state      <= ST_IDLE;
            end else begin
                cycle_cnt <= cycle_cnt + CW'(1);
                case (state)
                    ST_IDLE: begin
                        cycle_cnt  <= '0;
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        if (send) begin
                            tx_byte    <= data_in;
                            tx_parity  <= odd_parity(data_in);
                            bit_cnt    <= '0;
                            busy       <= 1'b1;
                            ps2_clk_oe <= 1'b1;
                            state      <= ST_INHIBIT;
                        end
                    end
                    ST_INHIBIT: begin
                        if (cycle_cnt == INHIBIT_LAST) begin
                            ps2_dat_oe <= 1'b1;
                            cycle_cnt  <= '0;
                            state      <= ST_REQUEST;
                        end
                    end
                    ST_REQUEST: begin
                        ps2_clk_oe <= 1'b0;
                        cycle_cnt  <= '0;
                        state      <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (fall_edge) begin
                            ps2_dat_oe <= ~tx_byte[bit_cnt];
                            bit_cnt    <= bit_cnt + 3'd1;
                            cycle_cnt  <= '0;
                            if (bit_cnt == 3'd7) begin
                                state <= ST_PARITY;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (fall_edge) begin
                            ps2_dat_oe <= ~tx_parity;
                            cycle_cnt  <= '0;
                            state      <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (fall_edge) begin
                            ps2_dat_oe <= 1'b0;
                            cycle_cnt  <= '0;
                            state      <= ST_ACK;
                        end
                    end
                    ST_ACK: begin
                        if (fall_edge) begin
                            cycle_cnt <= '0;
`ifdef PS2_HOST_TX_ACK_CHECK_EN
                            if (dat_sync) begin
                                error <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end else begin
                                state <= ST_WAIT_IDLE;
                            end
`else
                            state <= ST_WAIT_IDLE;
`endif
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (lines_idle) begin
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            cycle_cnt <= '0;
                            state     <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - bench for ps2_host_tx against a clocking PS/2 device model
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 40;
    localparam int TMO = 400;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       send    = 1'b0;
    logic       busy, done, error, ps2_clk_oe, ps2_dat_oe;
    logic       ps2_clk_in, ps2_dat_in;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int err_cyc = 0;
    int clk_run = 0;
    int clk_last = 0;
    int overlap = 0;
    int fall_cyc = 0;
    logic lat2, lat3;

    always #10 clock = ~clock;

    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .send       (send),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (done) done_cnt <= done_cnt + 1;
        if (error) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (done && error) both_cnt <= both_cnt + 1;
        if (ps2_clk_oe) begin
            clk_run <= clk_run + 1;
        end else begin
            if (clk_run != 0) clk_last <= clk_run;
            clk_run <= 0;
        end
        if (ps2_clk_oe && ps2_dat_oe) overlap <= overlap + 1;
    end

    initial begin
        repeat (60000) @(posedge clock);
        $display("FAIL watchdog: cycle budget exhausted, observed cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Expected line values seen by the device: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i + 1] = b[i];
        f[9]  = (($countones(b) % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic start_tx(input logic [7:0] b);
        data_in = b;
        send    = 1'b1;
        wait_cycles(1);
        check("accept_busy_clkoe_datoe", {busy, ps2_clk_oe, ps2_dat_oe}, 3'b110);
        send    = 1'b0;
        data_in = ~b;
    endtask

    // Device clocks 'falls' falling edges; samples mid-high; the 11th fall carries the ACK.
    task automatic dev_run(input int falls, input bit ack_low, output logic [10:0] frame);
        int h;
        bit found;
        h     = $urandom_range(10, 20);
        found = 1'b0;
        frame = 'x;
        for (int k = 0; k < INH + 50 && !found; k++) begin
            @(negedge clock);
            if (ps2_clk_in && !ps2_dat_in) found = 1'b1;
        end
        check("dev_request_seen", found, 1'b1);
        if (found) begin
            frame[0] = ps2_dat_in;
            wait_cycles(h);
            for (int i = 1; i <= falls; i++) begin
                if (i == 11) begin
                    dev_dat_low = ack_low;
                    wait_cycles(h / 2);
                end
                dev_clk_low = 1'b1;
                fall_cyc    = cyc;
                if (i == 1) begin
                    wait_cycles(2);
                    lat2 = ps2_dat_oe;
                    wait_cycles(1);
                    lat3 = ps2_dat_oe;
                    wait_cycles(h - 3);
                end else begin
                    wait_cycles(h);
                end
                dev_clk_low = 1'b0;
                if (i == 11) begin
                    dev_dat_low = 1'b0;
                end else begin
                    wait_cycles(h / 2);
                    frame[i] = ps2_dat_in;
                    wait_cycles(h - h / 2);
                end
            end
        end
    endtask

    task automatic wait_not_busy(input string tag, input int bound);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < bound) begin
            @(negedge clock);
            k++;
        end
        check({tag, "_busy_drops"}, busy, 1'b0);
    endtask

    initial begin
        logic [10:0] fr;
        logic [10:0] exp_fr;
        logic [7:0]  b;
        int d0, e0, ov0;

        wait_cycles(3);
        check("reset_outputs", {busy, done, error, ps2_clk_oe, ps2_dat_oe}, 5'b0);
        reset = 1'b0;
        wait_cycles(2);

        ov0 = overlap;
        start_tx(CMD_SET_LEDS);
        dev_run(11, 1'b1, fr);
        check("ed_frame", fr, frame_of(CMD_SET_LEDS));
        check("ed_frame_literal", fr, 11'b1_1_11101101_0);
        check("ed_clk_low_cycles", clk_last, INH);
        check("ed_request_overlap", overlap - ov0, 1);
        check("ed_dat_oe_before_3", lat2, 1'b1);
        check("ed_dat_oe_at_3", lat3, 1'b0);
        wait_not_busy("ed", 60);
        check("ed_done_with_busy_fall", done, 1'b1);
        start_tx(8'h01);
        check("ed_done_count", done_cnt, 1);
        check("ed_error_count", err_cnt, 0);

        dev_run(11, 1'b1, fr);
        check("x01_frame", fr, frame_of(8'h01));
        check("x01_parity_zero", fr[9], 1'b0);
        wait_not_busy("x01", 60);
        wait_cycles(1);
        check("x01_done_count", done_cnt, 2);

        for (int t = 0; t < 4; t++) begin
            b  = 8'($urandom);
            d0 = done_cnt;
            start_tx(b);
            dev_run(11, 1'b1, fr);
            check($sformatf("rand%0d_frame_%02h", t, b), fr, frame_of(b));
            wait_not_busy($sformatf("rand%0d", t), 60);
            wait_cycles(1);
            check($sformatf("rand%0d_done", t), done_cnt, d0 + 1);
        end

        b  = 8'($urandom);
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(b);
        dev_run(11, 1'b0, fr);
        wait_not_busy("noack", 60);
        wait_cycles(1);
`ifdef PS2_HOST_TX_ACK_CHECK_EN
        check("noack_error", err_cnt, e0 + 1);
        check("noack_no_done", done_cnt, d0);
`else
        check("noack_done", done_cnt, d0 + 1);
        check("noack_no_error", err_cnt, e0);
`endif
        check("noack_lines_released", {ps2_clk_oe, ps2_dat_oe}, 2'b00);

        b  = 8'($urandom);
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(b);
        dev_run(4, 1'b1, fr);
        exp_fr = frame_of(b);
        check("timeout_partial_frame", fr[4:0], exp_fr[4:0]);
        wait_not_busy("timeout", TMO + 100);
        wait_cycles(1);
        check("timeout_latency", err_cyc - fall_cyc, TMO + 3);
        check("timeout_error", err_cnt, e0 + 1);
        check("timeout_no_done", done_cnt, d0);
        check("timeout_lines_busy", {ps2_clk_oe, ps2_dat_oe, busy}, 3'b000);

        b  = 8'($urandom) & 8'hDF;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(b);
        dev_run(6, 1'b1, fr);
        check("midreset_dat_low_before", ps2_dat_oe, 1'b1);
        reset = 1'b1;
        wait_cycles(1);
        check("midreset_released", {ps2_clk_oe, ps2_dat_oe, busy}, 3'b000);
        reset = 1'b0;
        wait_cycles(4);
        check("midreset_no_pulses", {done_cnt - d0, err_cnt - e0}, 64'd0);
        start_tx(CMD_ECHO);
        dev_run(11, 1'b1, fr);
        check("after_reset_ee_frame", fr, frame_of(CMD_ECHO));
        wait_not_busy("after_reset_ee", 60);
        wait_cycles(1);
        check("after_reset_ee_done", done_cnt, d0 + 1);

        d0 = done_cnt;
        start_tx(CMD_ECHO);
        fork
            dev_run(11, 1'b1, fr);
            begin
                wait_cycles(INH + 60);
                data_in = CMD_RESET;
                send    = 1'b1;
                wait_cycles(1);
                check("busy_send_still_busy", busy, 1'b1);
                send    = 1'b0;
            end
        join
        check("busy_send_frame_is_ee", fr, frame_of(CMD_ECHO));
        wait_not_busy("busy_send", 60);
        wait_cycles(3 * INH);
        check("busy_send_one_done", done_cnt, d0 + 1);
        check("busy_send_no_second_tx", {ps2_clk_oe, busy}, 2'b00);

        check("never_done_and_error", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
